// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the I2S transmitter.
package audio_pkg;

  localparam int unsigned BCLK_HALF    = 16;
  localparam int unsigned SLOT_BITS    = 32;
  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned FRAME_CLKS   = 2 * SLOT_BITS * 2 * BCLK_HALF;

  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);
  localparam int unsigned IDX_W = $clog2(SAMPLE_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock divider: div/phase counters, bclk and bit-boundary strobes.
module bclk_divider #(
  parameter int unsigned HALF = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic bclk,
  output logic bit_start_c,
  output logic bit_end_c
);

  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_d;
  logic             phase;
  logic             phase_d;

  // Next counter values; bit_start_c flags that the coming cycle opens a bit period.
  always_comb begin
    div_d       = div;
    phase_d     = phase;
    bit_end_c   = count_en && (div == DIV_LAST) && phase;
    if (clear) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (count_en) begin
      if (div == DIV_LAST) begin
        div_d   = '0;
        phase_d = ~phase;
      end else begin
        div_d = div + DIV_W'(1);
      end
    end
    bit_start_c = !clear && (div_d == '0) && !phase_d;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      phase <= 1'b0;
    end else begin
      div   <= div_d;
      phase <= phase_d;
    end
  end

  assign bclk = phase;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: frame pacing, per-frame sample latch and serializer.
// Optional AUDIO_STEREO_EN adds sample_right_in for an independent right slot.
module i2s_transmitter
  import audio_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
`ifdef AUDIO_STEREO_EN
  input  logic [SAMPLE_WIDTH-1:0] sample_right_in,
`endif
  output logic                    new_frame,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata
);

  localparam logic [BIT_W-1:0] B_LAST   = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(2 * SLOT_BITS - 2);
  localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(SAMPLE_WIDTH);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_BITS + 1);
  localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_BITS + SAMPLE_WIDTH);

  state_t                  state;
  state_t                  state_d;
  logic                    count_en;
  logic                    clear;
  logic                    bit_start_c;
  logic                    bit_end_c;
  logic                    latch_c;
  logic [BIT_W-1:0]        b;
  logic [BIT_W-1:0]        b_d;
  logic                    lrclk_d;
  logic                    sdata_d;
  logic [IDX_W-1:0]        idx_l;
  logic [IDX_W-1:0]        idx_r;
  logic [SAMPLE_WIDTH-1:0] shadow_l;
  logic [SAMPLE_WIDTH-1:0] shadow_r_src;

  bclk_divider #(
    .HALF (BCLK_HALF)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .count_en    (count_en),
    .clear       (clear),
    .bclk        (bclk),
    .bit_start_c (bit_start_c),
    .bit_end_c   (bit_end_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // FSM next state: enable is the only run/idle control.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counters advance only while staying in RUN, zero whenever leaving it.
  always_comb begin
    count_en = (state == RUN) && enable;
    clear    = (state_d != RUN);
  end

  // Bit counter next value and last-cycle-of-frame latch strobe.
  always_comb begin
    b_d     = b;
    latch_c = bit_end_c && (b == B_LAST);
    if (clear) begin
      b_d = '0;
    end else if (bit_end_c) begin
      b_d = (b == B_LAST) ? '0 : b + BIT_W'(1);
    end
  end

  // Bit counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) b <= '0;
    else        b <= b_d;
  end

  // Shadow sample register(s), loaded once per frame.
`ifdef AUDIO_STEREO_EN
  logic [SAMPLE_WIDTH-1:0] shadow_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_l <= '0;
      shadow_r <= '0;
    end else if (latch_c) begin
      shadow_l <= sample_in;
      shadow_r <= sample_right_in;
    end
  end

  assign shadow_r_src = shadow_r;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       shadow_l <= '0;
    else if (latch_c) shadow_l <= sample_in;
  end

  assign shadow_r_src = shadow_l;
`endif

  // Word select and serial data for the bit period about to start.
  always_comb begin
    lrclk_d = !clear && (b_d >= LR_FIRST) && (b_d <= LR_LAST);
    idx_l   = IDX_W'(SAMPLE_WIDTH - 32'(b_d));
    idx_r   = IDX_W'(SAMPLE_WIDTH + SLOT_BITS - 32'(b_d));
    sdata_d = 1'b0;
    if (!clear) begin
      if ((b_d >= BIT_W'(1)) && (b_d <= L_LAST)) begin
        sdata_d = shadow_l[idx_l];
      end else if ((b_d >= R_FIRST) && (b_d <= R_LAST)) begin
        sdata_d = shadow_r_src[idx_r];
      end
    end
  end

  // Registered pin outputs, aligned with the counter state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_frame <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
    end else begin
      new_frame <= bit_start_c && (b_d == '0);
      lrclk     <= lrclk_d;
      sdata     <= sdata_d;
    end
  end

endmodule
